// File: rtl/mac_table_pkg.sv
// Shared types for the MAC table controller: FSM states, table entry layout and match helper.
package mac_table_pkg;

    localparam int PORT_WIDTH = 4;
    localparam int AGE_WIDTH  = 8;
    localparam int MAC_WIDTH  = 48;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SEARCH,
        S_WRITE,
        S_RESPOND
    } state_t;

    typedef struct packed {
        logic                  valid;
        logic [MAC_WIDTH-1:0]  mac;
        logic [PORT_WIDTH-1:0] port;
        logic [AGE_WIDTH-1:0]  age;
    } entry_t;

    function automatic logic entry_match(input entry_t entry, input logic [MAC_WIDTH-1:0] mac);
        return entry.valid && (entry.mac == mac);
    endfunction

endpackage

// File: rtl/mac_table_controller_arbiter.sv
// Combinational round-robin arbiter: first requesting client at or after rr_pointer wins.
// No state; the owner advances rr_pointer when a grant is consumed.
module round_robin_arbiter #(
    parameter int NUMBER_OF_CLIENTS = 2,
    parameter int INDEX_WIDTH       = 1
) (
    input  logic [NUMBER_OF_CLIENTS-1:0] request_valid,
    input  logic [INDEX_WIDTH-1:0]       rr_pointer,
    output logic [NUMBER_OF_CLIENTS-1:0] grant,
    output logic [INDEX_WIDTH-1:0]       grant_index,
    output logic                         grant_valid
);

    int candidate;

    // Walk offsets from farthest to nearest so the nearest requester is assigned last.
    always_comb begin
        grant       = '0;
        grant_index = '0;
        grant_valid = 1'b0;
        candidate   = 0;
        for (int i = NUMBER_OF_CLIENTS - 1; i >= 0; i--) begin
            candidate = int'(rr_pointer) + i;
            if (candidate >= NUMBER_OF_CLIENTS) begin
                candidate = candidate - NUMBER_OF_CLIENTS;
            end
            if (request_valid[candidate[INDEX_WIDTH-1:0]]) begin
                grant_valid = 1'b1;
                grant_index = candidate[INDEX_WIDTH-1:0];
            end
        end
        grant[grant_index] = grant_valid;
    end

endmodule

// File: rtl/mac_table_controller.sv
// Shared MAC table with round-robin request/response access; optional aging under MAC_TABLE_AGING_EN.
// Lookup responds k+3 cycles after capture (hit at entry k) or N+2 on miss, learns one cycle more; one request in flight.
module mac_table_controller
    import mac_table_pkg::*;
#(
    parameter int NUMBER_OF_CLIENTS = 2,
    parameter int NUMBER_OF_ENTRIES = 16,
    parameter int AGE_LIMIT         = 255
) (
    input  logic                                          clock,
    input  logic                                          reset_n,
    input  logic [NUMBER_OF_CLIENTS-1:0]                  request_valid,
    input  logic [NUMBER_OF_CLIENTS-1:0]                  request_write,
    input  logic [NUMBER_OF_CLIENTS-1:0][MAC_WIDTH-1:0]   request_mac,
    input  logic [NUMBER_OF_CLIENTS-1:0][PORT_WIDTH-1:0]  request_port,
    input  logic                                          age_tick,
    output logic [NUMBER_OF_CLIENTS-1:0]                  request_ready,
    output logic [NUMBER_OF_CLIENTS-1:0]                  response_valid,
    output logic                                          response_hit,
    output logic [PORT_WIDTH-1:0]                         response_port
);

    localparam int CW = (NUMBER_OF_CLIENTS > 1) ? $clog2(NUMBER_OF_CLIENTS) : 1;
    localparam int EW = $clog2(NUMBER_OF_ENTRIES);
    localparam logic [EW-1:0] LAST_INDEX  = EW'(NUMBER_OF_ENTRIES - 1);
    localparam logic [CW-1:0] LAST_CLIENT = CW'(NUMBER_OF_CLIENTS - 1);

    state_t                    state, next_state;
    entry_t                    entries [NUMBER_OF_ENTRIES];
    logic [EW-1:0]             index, free_index, hit_index, victim_pointer, write_target;
    logic                      free_found, hit_found, write_q, capture, entry_hit;
    logic [MAC_WIDTH-1:0]      mac_q;
    logic [PORT_WIDTH-1:0]     port_q, hit_port_q;
    logic [CW-1:0]             rr_pointer, grant_q, grant_index;
    logic [NUMBER_OF_CLIENTS-1:0] grant;
    logic                      grant_valid;

    round_robin_arbiter #(
        .NUMBER_OF_CLIENTS (NUMBER_OF_CLIENTS),
        .INDEX_WIDTH       (CW)
    ) u_arbiter (
        .request_valid (request_valid),
        .rr_pointer    (rr_pointer),
        .grant         (grant),
        .grant_index   (grant_index),
        .grant_valid   (grant_valid)
    );

    always_ff @(posedge clock) begin
        if (!reset_n) state <= S_IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        capture    = 1'b0;
        entry_hit  = entry_match(entries[index], mac_q);
        case (state)
            S_IDLE: begin
                if (grant_valid) begin
                    capture    = 1'b1;
                    next_state = S_SEARCH;
                end
            end
            S_SEARCH: begin
                if (entry_hit || index == LAST_INDEX) begin
                    next_state = write_q ? S_WRITE : S_RESPOND;
                end
            end
            S_WRITE:   next_state = S_RESPOND;
            S_RESPOND: next_state = S_IDLE;
            default:   next_state = S_IDLE;
        endcase
    end

    // Existing MAC is updated in place, so duplicates can never be created.
    assign write_target = hit_found ? hit_index : (free_found ? free_index : victim_pointer);

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            for (int i = 0; i < NUMBER_OF_ENTRIES; i++) entries[i] <= '0;
            request_ready  <= '0;
            response_valid <= '0;
            response_hit   <= 1'b0;
            response_port  <= '0;
            rr_pointer     <= '0;
            victim_pointer <= '0;
            index          <= '0;
            free_index     <= '0;
            hit_index      <= '0;
            free_found     <= 1'b0;
            hit_found      <= 1'b0;
            write_q        <= 1'b0;
            mac_q          <= '0;
            port_q         <= '0;
            hit_port_q     <= '0;
            grant_q        <= '0;
        end else begin
            request_ready  <= '0;
            response_valid <= '0;
`ifdef MAC_TABLE_AGING_EN
            if (age_tick) begin
                for (int i = 0; i < NUMBER_OF_ENTRIES; i++) begin
                    if (entries[i].valid) begin
                        if ({1'b0, entries[i].age} + 9'd1 == 9'(AGE_LIMIT)) entries[i].valid <= 1'b0;
                        entries[i].age <= entries[i].age + 8'd1;
                    end
                end
            end
`endif
            case (state)
                S_IDLE: begin
                    if (capture) begin
                        request_ready <= grant;
                        grant_q       <= grant_index;
                        rr_pointer    <= (grant_index == LAST_CLIENT) ? '0 : grant_index + CW'(1);
                        write_q       <= request_write[grant_index];
                        mac_q         <= request_mac[grant_index];
                        port_q        <= request_port[grant_index];
                        index         <= '0;
                        free_found    <= 1'b0;
                        hit_found     <= 1'b0;
                    end
                end
                S_SEARCH: begin
                    if (!entries[index].valid && !free_found) begin
                        free_index <= index;
                        free_found <= 1'b1;
                    end
                    if (entry_hit) begin
                        hit_found  <= 1'b1;
                        hit_index  <= index;
                        hit_port_q <= entries[index].port;
                    end else if (index != LAST_INDEX) begin
                        index <= index + EW'(1);
                    end
                end
                S_WRITE: begin
                    // Placed after aging so a same-cycle write leaves a fresh entry with age 0.
                    entries[write_target] <= '{valid: 1'b1, mac: mac_q, port: port_q, age: '0};
                    if (!hit_found && !free_found) victim_pointer <= victim_pointer + EW'(1);
                end
                S_RESPOND: begin
                    response_valid[grant_q] <= 1'b1;
                    response_hit            <= hit_found;
                    response_port           <= write_q ? port_q : (hit_found ? hit_port_q : '0);
                end
                default: ;
            endcase
        end
    end

`ifndef MAC_TABLE_AGING_EN
    logic unused_aging;
    always_comb begin
        unused_aging = age_tick ^ (AGE_LIMIT > 255);
        for (int i = 0; i < NUMBER_OF_ENTRIES; i++) unused_aging = unused_aging ^ (^entries[i].age);
    end
`endif

endmodule

// File: tb/tb_mac_table_controller.sv
// Directed bench for mac_table_controller: latency, learn/lookup, eviction, arbitration, aging, reset.
module tb_mac_table_controller;

    logic              clock = 1'b0;
    logic              reset_n = 1'b0;
    logic [1:0]        request_valid = '0;
    logic [1:0]        request_write = '0;
    logic [1:0][47:0]  request_mac = '0;
    logic [1:0][3:0]   request_port = '0;
    logic              age_tick = 1'b0;
    logic [1:0]        request_ready;
    logic [1:0]        response_valid;
    logic              response_hit;
    logic [3:0]        response_port;

    int checks = 0;
    int errors = 0;

    always #5 clock = ~clock;

    mac_table_controller #(
        .NUMBER_OF_CLIENTS (2),
        .NUMBER_OF_ENTRIES (16),
        .AGE_LIMIT         (2)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .request_valid  (request_valid),
        .request_write  (request_write),
        .request_mac    (request_mac),
        .request_port   (request_port),
        .age_tick       (age_tick),
        .request_ready  (request_ready),
        .response_valid (response_valid),
        .response_hit   (response_hit),
        .response_port  (response_port)
    );

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Issue one request; latencies are counted in cycles from the capture cycle.
    task automatic do_req(input int c, input logic wr, input logic [47:0] mac, input logic [3:0] port,
                          output logic hit, output logic [3:0] rport, output int rdy_n, output int rsp_n);
        @(negedge clock);
        request_valid[c] = 1'b1;
        request_write[c] = wr;
        request_mac[c]   = mac;
        request_port[c]  = port;
        rdy_n = -1;
        rsp_n = -1;
        hit   = 1'bx;
        rport = 4'hx;
        for (int n = 1; n <= 60; n++) begin
            @(negedge clock);
            if (request_ready[c] && rdy_n < 0) begin
                rdy_n = n;
                request_valid[c] = 1'b0;
            end
            if (response_valid[c]) begin
                rsp_n = n;
                hit   = response_hit;
                rport = response_port;
                break;
            end
        end
        request_valid[c] = 1'b0;
    endtask

    logic        hit;
    logic [3:0]  rport;
    int          rdy_n, rsp_n, seen_rsp;
    logic [1:0]  seen;
    logic [47:0] mac_a = 48'hAABB_CCDD_EEFF;
    logic [47:0] mac_17 = 48'h0300_0000_0011;

    initial begin
        repeat (3) @(negedge clock);
        check("reset_ready", request_ready, 2'b00);
        check("reset_rsp_valid", response_valid, 2'b00);
        check("reset_rsp_hit", response_hit, 1'b0);
        check("reset_rsp_port", response_port, 4'h0);
        reset_n = 1'b1;

        do_req(0, 1'b0, 48'h0011_2233_4455, 4'h0, hit, rport, rdy_n, rsp_n);
        check("empty_lookup_ready_lat", rdy_n, 1);
        check("empty_lookup_rsp_lat", rsp_n, 18);
        check("empty_lookup_hit", hit, 1'b0);
        check("empty_lookup_port", rport, 4'h0);

        do_req(1, 1'b1, mac_a, 4'h3, hit, rport, rdy_n, rsp_n);
        check("learn_a_lat", rsp_n, 19);
        check("learn_a_hit", hit, 1'b0);
        check("learn_a_port", rport, 4'h3);

        do_req(0, 1'b0, mac_a, 4'h0, hit, rport, rdy_n, rsp_n);
        check("lookup_a_lat", rsp_n, 3);
        check("lookup_a_hit", hit, 1'b1);
        check("lookup_a_port", rport, 4'h3);

        do_req(1, 1'b1, mac_a, 4'h3, hit, rport, rdy_n, rsp_n);
        check("relearn_a_lat", rsp_n, 4);
        check("relearn_a_hit", hit, 1'b1);
        do_req(0, 1'b1, mac_a, 4'h1, hit, rport, rdy_n, rsp_n);
        check("move_a_hit", hit, 1'b1);
        check("move_a_port", rport, 4'h1);
        do_req(1, 1'b0, mac_a, 4'h0, hit, rport, rdy_n, rsp_n);
        check("lookup_moved_a_port", rport, 4'h1);

        // Entry 0 holds mac_a; fifteen new MACs must land in entries 1..15.
        for (int i = 1; i <= 15; i++) begin
            do_req(i % 2, 1'b1, 48'h0200_0000_0000 + 48'(i), 4'(i), hit, rport, rdy_n, rsp_n);
            check("fill_hit", hit, 1'b0);
            check("fill_lat", rsp_n, 19);
        end
        do_req(0, 1'b0, 48'h0200_0000_0001, 4'h0, hit, rport, rdy_n, rsp_n);
        check("fill1_lat", rsp_n, 4);
        check("fill1_port", rport, 4'h1);
        do_req(1, 1'b0, 48'h0200_0000_000F, 4'h0, hit, rport, rdy_n, rsp_n);
        check("fill15_lat", rsp_n, 18);
        check("fill15_port", rport, 4'hF);

        do_req(0, 1'b1, mac_17, 4'h5, hit, rport, rdy_n, rsp_n);
        check("evict_learn_hit", hit, 1'b0);
        check("evict_learn_lat", rsp_n, 19);
        do_req(1, 1'b0, mac_a, 4'h0, hit, rport, rdy_n, rsp_n);
        check("evicted_a_hit", hit, 1'b0);
        check("evicted_a_port", rport, 4'h0);
        do_req(0, 1'b0, mac_17, 4'h0, hit, rport, rdy_n, rsp_n);
        check("mac17_lat", rsp_n, 3);
        check("mac17_port", rport, 4'h5);

        // Last capture was client 0, so client 1 next sets the pointer back to 0.
        do_req(1, 1'b0, 48'h0600_0000_0000, 4'h0, hit, rport, rdy_n, rsp_n);
        @(negedge clock);
        request_write = 2'b00;
        request_mac[0] = 48'h0700_0000_0000;
        request_mac[1] = 48'h0700_0000_0001;
        request_valid = 2'b11;
        for (int g = 0; g < 4; g++) begin
            seen = '0;
            for (int n = 0; n < 40; n++) begin
                @(negedge clock);
                if (request_ready != 2'b00) begin
                    seen = request_ready;
                    break;
                end
            end
            check("arb_grant", seen, (g % 2 == 0) ? 2'b01 : 2'b10);
        end
        request_valid = 2'b00;
        for (int n = 0; n < 40; n++) begin
            @(negedge clock);
            if (response_valid != 2'b00) break;
        end

        do_req(0, 1'b1, 48'h0400_0000_0000, 4'h9, hit, rport, rdy_n, rsp_n);
        repeat (2) begin
            @(negedge clock);
            age_tick = 1'b1;
            @(negedge clock);
            age_tick = 1'b0;
        end
        do_req(1, 1'b0, 48'h0400_0000_0000, 4'h0, hit, rport, rdy_n, rsp_n);
`ifdef MAC_TABLE_AGING_EN
        check("aged_hit", hit, 1'b0);
        check("aged_port", rport, 4'h0);
`else
        check("aged_hit", hit, 1'b1);
        check("aged_port", rport, 4'h9);
`endif

        // Reset in the middle of a learn: no response may appear and the table must be empty.
        @(negedge clock);
        request_valid[0] = 1'b1;
        request_write[0] = 1'b1;
        request_mac[0]   = 48'h0500_0000_0000;
        request_port[0]  = 4'h2;
        seen_rsp = 0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clock);
            if (request_ready[0]) request_valid[0] = 1'b0;
            if (response_valid != 2'b00) seen_rsp++;
        end
        request_valid[0] = 1'b0;
        reset_n = 1'b0;
        repeat (2) begin
            @(negedge clock);
            if (response_valid != 2'b00) seen_rsp++;
        end
        check("midreset_ready", request_ready, 2'b00);
        check("midreset_port", response_port, 4'h0);
        reset_n = 1'b1;
        for (int n = 0; n < 25; n++) begin
            @(negedge clock);
            if (response_valid != 2'b00) seen_rsp++;
        end
        check("midreset_no_response", seen_rsp, 0);
        do_req(0, 1'b0, mac_17, 4'h0, hit, rport, rdy_n, rsp_n);
        check("cleared_mac17_hit", hit, 1'b0);
        check("cleared_mac17_lat", rsp_n, 18);
        do_req(1, 1'b0, 48'h0500_0000_0000, 4'h0, hit, rport, rdy_n, rsp_n);
        check("dropped_learn_hit", hit, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mac_table_controller.md
# mac_table_controller

Owns the switch MAC address table and shares it between several requesters: per-port learning engines (source MAC writes) and forwarding engines (destination MAC lookups). Holds NUMBER_OF_ENTRIES entries of {valid, mac, port}, grants one request at a time round-robin, scans entries one per cycle, and returns hit/port per client. Sits between the per-port data orchestrators and the forwarding decision. It replaces direct CAM address/data access with a request/response interface.

## Interface
- NUMBER_OF_CLIENTS, 2, number of requesters (≥1)
- NUMBER_OF_ENTRIES, 16, table depth (power of two, ≥2)
- AGE_LIMIT, 255, age_tick count at which an entry expires (≤255)
- clock  input  1  clock
- reset_n  input  1  reset, synchronous, active-low
- request_valid  input  [NUMBER_OF_CLIENTS-1:0]  request pending, held until request_ready
- request_write  input  [NUMBER_OF_CLIENTS-1:0]  1 = learn, 0 = lookup
- request_mac  input  [NUMBER_OF_CLIENTS-1:0][47:0]  MAC to learn/look up
- request_port  input  [NUMBER_OF_CLIENTS-1:0][3:0]  port to learn (ignored on lookup)
- age_tick  input  1  one-cycle aging pulse
- request_ready  output  [NUMBER_OF_CLIENTS-1:0]  one-cycle capture pulse
- response_valid  output  [NUMBER_OF_CLIENTS-1:0]  one-cycle completion pulse to the granted client
- response_hit  output  1  MAC was present before this request
- response_port  output  [3:0]  stored port on lookup hit; 0 on miss; learned port on write

## Operation
- States: S_IDLE, S_SEARCH, S_WRITE, S_RESPOND.
- S_IDLE: if any request_valid, grant the first valid client at or after rr_pointer (circular). Latch its mac/port/write, pulse request_ready[grant], set index=0, go S_SEARCH. rr_pointer becomes grant+1 mod NUMBER_OF_CLIENTS at capture.
- S_SEARCH: compare entry[index] (valid && mac equal). Track lowest invalid index as free_index. On hit or index==NUMBER_OF_ENTRIES-1: go S_WRITE if write, else S_RESPOND. Otherwise index+1.
- S_WRITE: target = hit entry (port overwritten); else free_index; else table full -> entry[victim_pointer], victim_pointer+1 mod NUMBER_OF_ENTRIES. Target gets valid=1, mac, port, age=0. Go S_RESPOND.
- S_RESPOND: register response_valid[grant], response_hit, response_port. Go S_IDLE.
- Duplicate MACs never exist: a learn to an existing MAC updates in place.
- Client holds request_valid/data stable until request_ready; it may reassert a new request the cycle after ready.

## Timing
- Reset values: request_ready=0, response_valid=0, response_hit=0, response_port=0; all entries invalid; rr_pointer=0; victim_pointer=0; state S_IDLE.
- Request captured in cycle T (ready visible T+1).
- Lookup, hit at entry k: response_valid in T+k+3. Lookup miss: T+NUMBER_OF_ENTRIES+2.
- Learn: one cycle longer than the equivalent lookup.
- Next capture is possible in the cycle response_valid is high.
- Reset mid-operation: the request is dropped, no response, and the table is cleared.
- Simultaneous requests: only one grant per capture; losers keep request_valid high.

## Configuration
- MAC_TABLE_AGING_EN defined: each entry carries an 8-bit age.
  - age_tick increments the age of every valid entry.
  - An entry whose age reaches AGE_LIMIT is invalidated in that cycle.
  - When a write targets an entry in the same cycle as age_tick, the write wins and the age is 0.
  - Lookups do not refresh age.
- MAC_TABLE_AGING_EN undefined: no age storage, age_tick ignored, entries persist until reset or eviction.

## Structure
- Package mac_table_pkg: state enum, entry struct typedef {valid, mac[47:0], port[3:0], age[7:0]}, constants PORT_WIDTH=4, AGE_WIDTH=8.
- Sub-module round_robin_arbiter: combinational grant one-hot/index from request_valid and rr_pointer.

## Test plan
- Lookup of 48'h0011_2233_4455 on an empty table from client 0 -> ready at T+1, response_valid[0] at T+18, hit=0, port=0.
- Client 1 learns 48'hAABB_CCDD_EEFF on port 3, then client 0 looks it up -> write goes to entry 0; lookup hit=1, port=3, response at T+3.
- Learn the same MAC on port 3, then on port 1 -> second response hit=1; later lookup returns port 1; only one valid entry.
- Fill 16 distinct MACs, then learn a 17th -> entry 0 evicted (victim_pointer 0→1); lookup of the first MAC misses.
- Both clients hold request_valid continuously -> grants alternate 0,1,0,1; no client starves.
- With MAC_TABLE_AGING_EN and AGE_LIMIT=2: learn a MAC, pulse age_tick twice -> lookup misses. Without the macro -> lookup still hits.
